// File: rtl/eeprom_pkg.sv
// ---------------------------------------------------------------------------
// eeprom_pkg
// Shared definitions for the parameter keeper and the 3-byte EEPROM stage:
//   - state_t      : keeper FSM state encoding
//   - DEF_P0..P2   : fallback parameter bytes used when a load fails
//   - B*_HI/B*_LO  : bit-field positions of the three bytes in the 24-bit
//                    word ({byte0, byte1, byte2}, byte0 in the MSBs)
//   - pack3()      : assembles three bytes into the 24-bit word
// ---------------------------------------------------------------------------
package eeprom_pkg;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_LOAD_REQ  = 3'd1,
        ST_LOAD_WAIT = 3'd2,
        ST_IDLE      = 3'd3,
        ST_SAVE_REQ  = 3'd4,
        ST_SAVE_WAIT = 3'd5
    } state_t;

    localparam logic [7:0] DEF_P0 = 8'd30;
    localparam logic [7:0] DEF_P1 = 8'd20;
    localparam logic [7:0] DEF_P2 = 8'd10;

    localparam int B0_HI = 23;
    localparam int B0_LO = 16;
    localparam int B1_HI = 15;
    localparam int B1_LO = 8;
    localparam int B2_HI = 7;
    localparam int B2_LO = 0;

    function automatic logic [23:0] pack3(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2);
        logic [23:0] w;
        w              = '0;
        w[B0_HI:B0_LO] = b0;
        w[B1_HI:B1_LO] = b1;
        w[B2_HI:B2_LO] = b2;
        return w;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// ---------------------------------------------------------------------------
// timeout_counter
// Cycle counter with clear/enable/expire interface. While en is high the
// count advances once per cycle and holds at LIMIT-1; expire is high in the
// cycle where en is high and the count has reached LIMIT-1. clr has priority
// over en.
// Ports:
//   sclk   in  system clock
//   nrst   in  asynchronous active-low reset
//   clr    in  synchronous clear of the count
//   en     in  count enable
//   expire out LIMIT cycles of enable have elapsed
// ---------------------------------------------------------------------------
module timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic sclk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int              W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0]    LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/eeprom_param_keeper.sv
// ---------------------------------------------------------------------------
// eeprom_param_keeper
// Parameter-persistence controller in front of the 3-byte EEPROM stage.
// After reset it waits BOOT_DELAY_CYC cycles, reads three bytes and
// publishes them (or the defaults on timeout). Save requests latch the live
// parameter bytes and write them; a request arriving while busy is queued
// (collapsed to one) and takes the newest values when it is accepted.
// Every transaction is bounded by TIMEOUT_CYC.
//
// Optional feature (macro PARAM_RANGE_CHECK_EN): a successfully loaded byte
// above PARAM_MAX replaces all outputs by the defaults, raises err and
// queues a write-back of the defaults.
//
// Ports:
//   sclk, nrst                        clock, asynchronous active-low reset
//   param0_in..param2_in              live values to save
//   save_req                          1-cycle save request
//   param0_out..param2_out            loaded parameter values
//   load_valid                        1-cycle pulse when a load updates outputs
//   ready                             boot load finished (ok or fallback)
//   busy                              transaction outstanding or queued
//   err                               error flag (timeout / range failure)
//   start_reg_addr                    constant START_ADDR
//   write_3bytes                      bytes latched at save acceptance
//   read_3bytes                       bytes from the downstream stage
//   write_3bytes_trig/read_3bytes_trig  1-cycle triggers to downstream
//   write_3bytes_done/read_3bytes_done  1-cycle completions from downstream
// ---------------------------------------------------------------------------
module eeprom_param_keeper
    import eeprom_pkg::*;
#(
    parameter logic [7:0] START_ADDR     = 8'h00,
    parameter int         BOOT_DELAY_CYC = 500_000,
    parameter int         TIMEOUT_CYC    = 2_500_000,
    parameter logic [7:0] PARAM_MAX      = 8'd99,
    parameter logic [7:0] DEF0           = DEF_P0,
    parameter logic [7:0] DEF1           = DEF_P1,
    parameter logic [7:0] DEF2           = DEF_P2
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic [7:0]  param0_in,
    input  logic [7:0]  param1_in,
    input  logic [7:0]  param2_in,
    input  logic        save_req,
    output logic [7:0]  param0_out,
    output logic [7:0]  param1_out,
    output logic [7:0]  param2_out,
    output logic        load_valid,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [7:0]  start_reg_addr,
    output logic [23:0] write_3bytes,
    input  logic [23:0] read_3bytes,
    output logic        write_3bytes_trig,
    output logic        read_3bytes_trig,
    input  logic        write_3bytes_done,
    input  logic        read_3bytes_done
);

`ifdef PARAM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    state_t     state, state_n;
    logic       save_pending, pending_n;
    logic       wb_defaults;
    logic       boot_expire, txn_expire;
    logic       load_ok, load_to, save_accept, save_ok, save_to;
    logic       range_bad;
    logic [7:0] rd_b0, rd_b1, rd_b2;

    assign start_reg_addr = START_ADDR;

    assign rd_b0 = read_3bytes[B0_HI:B0_LO];
    assign rd_b1 = read_3bytes[B1_HI:B1_LO];
    assign rd_b2 = read_3bytes[B2_HI:B2_LO];

    assign range_bad = RANGE_EN &&
                       ((rd_b0 > PARAM_MAX) || (rd_b1 > PARAM_MAX) || (rd_b2 > PARAM_MAX));

    // Boot settle delay; the counter is held cleared outside BOOT.
    timeout_counter #(.LIMIT(BOOT_DELAY_CYC)) u_boot_cnt (
        .sclk   (sclk),
        .nrst   (nrst),
        .clr    (state != ST_BOOT),
        .en     (state == ST_BOOT),
        .expire (boot_expire)
    );

    // Transaction timeout; cleared in the REQ state so it starts at the trigger.
    timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_txn_cnt (
        .sclk   (sclk),
        .nrst   (nrst),
        .clr    ((state == ST_LOAD_REQ) || (state == ST_SAVE_REQ)),
        .en     ((state == ST_LOAD_WAIT) || (state == ST_SAVE_WAIT)),
        .expire (txn_expire)
    );

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_n;
        end
    end

    // Done is checked before timeout so a coincident done counts as success.
    always_comb begin
        state_n     = state;
        load_ok     = 1'b0;
        load_to     = 1'b0;
        save_accept = 1'b0;
        save_ok     = 1'b0;
        save_to     = 1'b0;
        case (state)
            ST_BOOT: begin
                if (boot_expire) state_n = ST_LOAD_REQ;
            end
            ST_LOAD_REQ: begin
                state_n = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (read_3bytes_done) begin
                    load_ok = 1'b1;
                    state_n = ST_IDLE;
                end else if (txn_expire) begin
                    load_to = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (save_req || save_pending) begin
                    save_accept = 1'b1;
                    state_n     = ST_SAVE_REQ;
                end
            end
            ST_SAVE_REQ: begin
                state_n = ST_SAVE_WAIT;
            end
            ST_SAVE_WAIT: begin
                if (write_3bytes_done) begin
                    save_ok = 1'b1;
                    state_n = ST_IDLE;
                end else if (txn_expire) begin
                    save_to = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

    // Requests outside IDLE collapse into a single pending flag.
    always_comb begin
        pending_n = save_pending;
        if (save_accept) begin
            pending_n = 1'b0;
        end else if (save_req && (state != ST_IDLE)) begin
            pending_n = 1'b1;
        end
        if (load_ok && range_bad) begin
            pending_n = 1'b1;
        end
    end

    // Control registers. Triggers are registered from the REQ state, so the
    // pulse appears while the FSM already waits for the matching done.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            save_pending      <= 1'b0;
            wb_defaults       <= 1'b0;
            busy              <= 1'b0;
            ready             <= 1'b0;
            err               <= 1'b0;
            load_valid        <= 1'b0;
            read_3bytes_trig  <= 1'b0;
            write_3bytes_trig <= 1'b0;
        end else begin
            save_pending      <= pending_n;
            busy              <= !((state_n == ST_IDLE) && !pending_n);
            load_valid        <= load_ok | load_to;
            read_3bytes_trig  <= (state == ST_LOAD_REQ);
            write_3bytes_trig <= (state == ST_SAVE_REQ);
            if (load_ok || load_to) ready <= 1'b1;
            if (load_ok) begin
                err <= range_bad;
            end else if (load_to || save_to) begin
                err <= 1'b1;
            end else if (save_ok) begin
                err <= 1'b0;
            end
            if (save_accept) begin
                wb_defaults <= 1'b0;
            end else if (load_ok && range_bad) begin
                wb_defaults <= 1'b1;
            end
        end
    end

    // Published parameters and the write word.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            param0_out   <= DEF0;
            param1_out   <= DEF1;
            param2_out   <= DEF2;
            write_3bytes <= '0;
        end else begin
            if ((load_ok && range_bad) || load_to) begin
                param0_out <= DEF0;
                param1_out <= DEF1;
                param2_out <= DEF2;
            end else if (load_ok) begin
                param0_out <= rd_b0;
                param1_out <= rd_b1;
                param2_out <= rd_b2;
            end
            if (save_accept) begin
                write_3bytes <= wb_defaults ? pack3(DEF0, DEF1, DEF2)
                                            : pack3(param0_in, param1_in, param2_in);
            end
        end
    end

endmodule
